issue_unit_scheduler: RTL and testbench

// Per-SM issue unit (IU): arbitrates req_IB_IU from NUM_WARPS IBuffer instances, one issue grant per cycle.

---
 rtl/issue_unit_scheduler_if.sv | 34 +++
 rtl/issue_unit_scheduler.sv | 106 ++++++++++
 tb/tb_issue_unit_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_unit_scheduler_if.sv
// Issue-unit bus: IBuffer issue/exit requests, RAU launch/retire handshake, OC select.
// The master side (IBuffers, RAU, OC) drives requests; the slave side is the scheduler.
interface issue_unit_scheduler_if #(
  parameter int NUM_WARPS = 8,
  parameter int WID_W     = 3
);
  logic                 launch_valid_RAU;
  logic [WID_W-1:0]     launch_wid_RAU;
  logic [NUM_WARPS-1:0] req_IB_IU;
  logic [NUM_WARPS-1:0] grt_IU_IB;
  logic [NUM_WARPS-1:0] exit_req_IB_IU;
  logic [NUM_WARPS-1:0] exit_grt_IU_IB;
  logic                 stall_OC_IU;
  logic                 valid_IU_OC;
  logic [WID_W-1:0]     wid_IU_OC;
  logic                 exit_valid_IU_RAU;
  logic [WID_W-1:0]     exit_wid_IU_RAU;
  logic                 exit_ack_RAU_IU;
  logic [NUM_WARPS-1:0] active_IU;

  modport master (
    output launch_valid_RAU, launch_wid_RAU, req_IB_IU, exit_req_IB_IU,
           stall_OC_IU, exit_ack_RAU_IU,
    input  grt_IU_IB, exit_grt_IU_IB, valid_IU_OC, wid_IU_OC,
           exit_valid_IU_RAU, exit_wid_IU_RAU, active_IU
  );

  modport slave (
    input  launch_valid_RAU, launch_wid_RAU, req_IB_IU, exit_req_IB_IU,
           stall_OC_IU, exit_ack_RAU_IU,
    output grt_IU_IB, exit_grt_IU_IB, valid_IU_OC, wid_IU_OC,
           exit_valid_IU_RAU, exit_wid_IU_RAU, active_IU
  );
endinterface

// File: rtl/issue_unit_scheduler.sv
// Per-SM issue unit: round-robin issue arbitration over active warps plus a
// serialised warp-exit handshake with the RAU.
module issue_unit_scheduler #(
  parameter int NUM_WARPS = 8,
  parameter int WID_W     = 3
) (
  input logic                   clk,
  input logic                   rst,
  issue_unit_scheduler_if.slave bus
);
  typedef enum logic {S_IDLE, S_WAIT_ACK} exit_state_t;

  exit_state_t          r_state;
  logic [NUM_WARPS-1:0] r_active;
  logic [WID_W-1:0]     r_rr_ptr;
  logic [WID_W-1:0]     r_exit_wid;
  logic                 r_exit_valid;

  logic [NUM_WARPS-1:0] w_exit_cand;
  logic [NUM_WARPS-1:0] w_exit_grt;
  logic [NUM_WARPS-1:0] w_exiting;
  logic [NUM_WARPS-1:0] w_launch_mask;
  logic [NUM_WARPS-1:0] w_eligible;
  logic [NUM_WARPS-1:0] w_grt;
  logic [WID_W-1:0]     w_exit_id;
  logic [WID_W-1:0]     w_wid;
  logic [WID_W-1:0]     w_idx;
  logic                 w_exit_any;
  logic                 w_grant_any;

  assign w_exit_cand = bus.exit_req_IB_IU & r_active;
  assign w_exit_any  = (r_state == S_IDLE) && (w_exit_cand != '0);

  // Lowest-index exit candidate wins.
  always_comb begin
    w_exit_id = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      if (w_exit_cand[i]) w_exit_id = WID_W'(i);
    end
  end

  // A warp is barred from issue both in its exit-grant cycle and while held by the FSM.
  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
    assign w_exit_grt[gi]    = w_exit_any && (w_exit_id == WID_W'(gi));
    assign w_exiting[gi]     = w_exit_grt[gi] ||
                               ((r_state == S_WAIT_ACK) && (r_exit_wid == WID_W'(gi)));
    assign w_launch_mask[gi] = bus.launch_valid_RAU && (bus.launch_wid_RAU == WID_W'(gi));
  end

  assign w_eligible = bus.req_IB_IU & r_active & ~w_exiting;

  // Search rr_ptr, rr_ptr+1, ...; the index wraps for free since NUM_WARPS is a power of 2.
  always_comb begin
    w_grt       = '0;
    w_wid       = '0;
    w_idx       = '0;
    w_grant_any = 1'b0;
    if (!bus.stall_OC_IU) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        w_idx = r_rr_ptr + WID_W'(i);
        if (!w_grant_any && w_eligible[w_idx]) begin
          w_grant_any  = 1'b1;
          w_grt[w_idx] = 1'b1;
          w_wid        = w_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_active     <= '0;
      r_rr_ptr     <= '0;
      r_exit_wid   <= '0;
      r_exit_valid <= 1'b0;
    end else begin
      // Launch is OR-ed in after the exit clear so a same-cycle relaunch keeps the bit.
      r_active <= (r_active & ~w_exit_grt) | w_launch_mask;
      if (w_grant_any) r_rr_ptr <= w_wid + WID_W'(1);
      case (r_state)
        S_IDLE: begin
          if (w_exit_any) begin
            r_state      <= S_WAIT_ACK;
            r_exit_valid <= 1'b1;
            r_exit_wid   <= w_exit_id;
          end
        end
        S_WAIT_ACK: begin
          if (bus.exit_ack_RAU_IU) begin
            r_state      <= S_IDLE;
            r_exit_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.grt_IU_IB         = w_grt;
  assign bus.valid_IU_OC       = w_grant_any;
  assign bus.wid_IU_OC         = w_wid;
  assign bus.exit_grt_IU_IB    = w_exit_grt;
  assign bus.exit_valid_IU_RAU = r_exit_valid;
  assign bus.exit_wid_IU_RAU   = r_exit_wid;
  assign bus.active_IU         = r_active;
endmodule

// File: tb/tb_issue_unit_scheduler.sv
// Self-checking bench for issue_unit_scheduler: per-scenario tasks, expected grant IDs
// queued when stimulus is applied and popped when the DUT asserts a grant.
module tb_issue_unit_scheduler;
  localparam int NW = 8;
  localparam int WW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_unit_scheduler_if #(.NUM_WARPS(NW), .WID_W(WW)) bus ();
  issue_unit_scheduler #(.NUM_WARPS(NW), .WID_W(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] exit_q[$];
  logic [WW-1:0] exp_w;
  logic [NW-1:0] one_hot;

  task automatic drive_idle();
    bus.launch_valid_RAU = 1'b0;
    bus.launch_wid_RAU   = '0;
    bus.req_IB_IU        = '0;
    bus.exit_req_IB_IU   = '0;
    bus.stall_OC_IU      = 1'b0;
    bus.exit_ack_RAU_IU  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int w);
    bus.launch_valid_RAU = 1'b1;
    bus.launch_wid_RAU   = WW'(w);
    next_cycle();
    bus.launch_valid_RAU = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    #3;
    checks++;
    if (bus.active_IU !== 8'h00 || bus.grt_IU_IB !== 8'h00 || bus.valid_IU_OC !== 1'b0 ||
        bus.wid_IU_OC !== 3'd0 || bus.exit_grt_IU_IB !== 8'h00 ||
        bus.exit_valid_IU_RAU !== 1'b0 || bus.exit_wid_IU_RAU !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: active=%h grt=%h valid=%b wid=%0d exit_grt=%h exit_valid=%b exit_wid=%0d, required all zero",
               bus.active_IU, bus.grt_IU_IB, bus.valid_IU_OC, bus.wid_IU_OC,
               bus.exit_grt_IU_IB, bus.exit_valid_IU_RAU, bus.exit_wid_IU_RAU);
    end
    $display("reset: active=%h exit_valid=%b", bus.active_IU, bus.exit_valid_IU_RAU);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_round_robin();
    for (int w = 0; w < 4; w++) launch(w);
    @(negedge clk);
    checks++;
    if (bus.active_IU !== 8'h0F) begin
      errors++;
      $display("FAIL rr_active: active=%h required 0f", bus.active_IU);
    end
    next_cycle();
    bus.req_IB_IU = 8'h0F;
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.valid_IU_OC !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL rr_valid cycle %0d: valid=%b required 1", c, bus.valid_IU_OC);
      end else begin
        exp_w = exp_q.pop_front();
        one_hot = NW'(1) << exp_w;
        checks++;
        if (bus.wid_IU_OC !== exp_w || bus.grt_IU_IB !== one_hot) begin
          errors++;
          $display("FAIL rr_grant cycle %0d: grt=%h wid=%0d required grt=%h wid=%0d",
                   c, bus.grt_IU_IB, bus.wid_IU_OC, one_hot, exp_w);
        end
      end
      $display("rr cycle %0d: grt=%h wid=%0d", c, bus.grt_IU_IB, bus.wid_IU_OC);
      next_cycle();
    end
    bus.req_IB_IU = '0;
  endtask

  task automatic test_wrap();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    next_cycle();
    launch(0);
    launch(5);
    launch(6);
    bus.req_IB_IU = 8'h20;
    exp_q = '{3'd5, 3'd6, 3'd0, 3'd6};
    for (int c = 0; c < 4; c++) begin
      if (c == 1) bus.req_IB_IU = 8'h41;
      @(negedge clk);
      checks++;
      if (bus.valid_IU_OC !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL wrap_valid cycle %0d: valid=%b required 1", c, bus.valid_IU_OC);
      end else begin
        exp_w = exp_q.pop_front();
        one_hot = NW'(1) << exp_w;
        checks++;
        if (bus.wid_IU_OC !== exp_w || bus.grt_IU_IB !== one_hot) begin
          errors++;
          $display("FAIL wrap_grant cycle %0d: grt=%h wid=%0d required grt=%h wid=%0d",
                   c, bus.grt_IU_IB, bus.wid_IU_OC, one_hot, exp_w);
        end
      end
      $display("wrap cycle %0d: req=%h grt=%h wid=%0d", c, bus.req_IB_IU, bus.grt_IU_IB, bus.wid_IU_OC);
      next_cycle();
    end
    bus.req_IB_IU = '0;
  endtask

  task automatic test_stall();
    for (int w = 0; w < NW; w++) launch(w);
    bus.req_IB_IU   = 8'hFF;
    bus.stall_OC_IU = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus.grt_IU_IB !== 8'h00 || bus.valid_IU_OC !== 1'b0 || bus.wid_IU_OC !== 3'd0) begin
        errors++;
        $display("FAIL stall_suppress cycle %0d: grt=%h valid=%b wid=%0d required 00/0/0",
                 c, bus.grt_IU_IB, bus.valid_IU_OC, bus.wid_IU_OC);
      end
      $display("stall cycle %0d: grt=%h valid=%b", c, bus.grt_IU_IB, bus.valid_IU_OC);
      next_cycle();
    end
    bus.stall_OC_IU = 1'b0;
    exp_q = '{3'd7, 3'd0};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus.valid_IU_OC !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL stall_resume_valid cycle %0d: valid=%b required 1", c, bus.valid_IU_OC);
      end else begin
        exp_w = exp_q.pop_front();
        one_hot = NW'(1) << exp_w;
        checks++;
        if (bus.wid_IU_OC !== exp_w || bus.grt_IU_IB !== one_hot) begin
          errors++;
          $display("FAIL stall_resume cycle %0d: grt=%h wid=%0d required grt=%h wid=%0d",
                   c, bus.grt_IU_IB, bus.wid_IU_OC, one_hot, exp_w);
        end
      end
      $display("resume cycle %0d: grt=%h wid=%0d", c, bus.grt_IU_IB, bus.wid_IU_OC);
      next_cycle();
    end
    bus.req_IB_IU = '0;
  endtask

  task automatic test_exit();
    bus.exit_req_IB_IU = 8'h0A;
    exit_q = '{3'd1, 3'd3};
    @(negedge clk);
    checks++;
    if (bus.exit_grt_IU_IB !== 8'h02 || bus.exit_valid_IU_RAU !== 1'b0) begin
      errors++;
      $display("FAIL exit_first_grant: exit_grt=%h exit_valid=%b required 02/0",
               bus.exit_grt_IU_IB, bus.exit_valid_IU_RAU);
    end
    $display("exit grant: exit_grt=%h", bus.exit_grt_IU_IB);
    next_cycle();
    exp_w = exit_q.pop_front();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) bus.exit_ack_RAU_IU = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.exit_grt_IU_IB !== 8'h00 || bus.exit_valid_IU_RAU !== 1'b1 ||
          bus.exit_wid_IU_RAU !== exp_w || bus.active_IU !== 8'hFD) begin
        errors++;
        $display("FAIL exit_wait cycle %0d: exit_grt=%h valid=%b wid=%0d active=%h required 00/1/%0d/fd",
                 c, bus.exit_grt_IU_IB, bus.exit_valid_IU_RAU, bus.exit_wid_IU_RAU,
                 bus.active_IU, exp_w);
      end
      $display("exit wait %0d: valid=%b wid=%0d ack=%b", c, bus.exit_valid_IU_RAU,
               bus.exit_wid_IU_RAU, bus.exit_ack_RAU_IU);
      next_cycle();
    end
    bus.exit_ack_RAU_IU = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.exit_grt_IU_IB !== 8'h08 || bus.exit_valid_IU_RAU !== 1'b0) begin
      errors++;
      $display("FAIL exit_second_grant: exit_grt=%h exit_valid=%b required 08/0",
               bus.exit_grt_IU_IB, bus.exit_valid_IU_RAU);
    end
    $display("exit grant: exit_grt=%h", bus.exit_grt_IU_IB);
    next_cycle();
    bus.exit_req_IB_IU = '0;
    exp_w = exit_q.pop_front();
    @(negedge clk);
    checks++;
    if (bus.exit_valid_IU_RAU !== 1'b1 || bus.exit_wid_IU_RAU !== exp_w || bus.active_IU !== 8'hF5) begin
      errors++;
      $display("FAIL exit_second_wait: valid=%b wid=%0d active=%h required 1/%0d/f5",
               bus.exit_valid_IU_RAU, bus.exit_wid_IU_RAU, bus.active_IU, exp_w);
    end
    $display("exit wait: valid=%b wid=%0d active=%h", bus.exit_valid_IU_RAU,
             bus.exit_wid_IU_RAU, bus.active_IU);
    next_cycle();
    bus.exit_ack_RAU_IU = 1'b1;
    next_cycle();
    bus.exit_ack_RAU_IU = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.exit_valid_IU_RAU !== 1'b0) begin
      errors++;
      $display("FAIL exit_release: exit_valid=%b required 0", bus.exit_valid_IU_RAU);
    end
    next_cycle();
  endtask

  task automatic test_exit_issue_conflict();
    launch(1);
    bus.req_IB_IU      = 8'h04;
    bus.exit_req_IB_IU = 8'h04;
    @(negedge clk);
    checks++;
    if (bus.exit_grt_IU_IB !== 8'h04 || bus.grt_IU_IB !== 8'h00 || bus.valid_IU_OC !== 1'b0) begin
      errors++;
      $display("FAIL conflict_same_warp: exit_grt=%h grt=%h valid=%b required 04/00/0",
               bus.exit_grt_IU_IB, bus.grt_IU_IB, bus.valid_IU_OC);
    end
    $display("conflict: exit_grt=%h grt=%h", bus.exit_grt_IU_IB, bus.grt_IU_IB);
    next_cycle();
    bus.req_IB_IU      = 8'h06;
    bus.exit_req_IB_IU = 8'h00;
    exp_q.push_back(3'd1);
    @(negedge clk);
    checks++;
    if (bus.valid_IU_OC !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL conflict_issue_valid: valid=%b required 1", bus.valid_IU_OC);
    end else begin
      exp_w = exp_q.pop_front();
      one_hot = NW'(1) << exp_w;
      checks++;
      if (bus.grt_IU_IB !== one_hot || bus.wid_IU_OC !== exp_w ||
          bus.exit_valid_IU_RAU !== 1'b1 || bus.exit_wid_IU_RAU !== 3'd2) begin
        errors++;
        $display("FAIL conflict_issue: grt=%h wid=%0d exit_valid=%b exit_wid=%0d required %h/%0d/1/2",
                 bus.grt_IU_IB, bus.wid_IU_OC, bus.exit_valid_IU_RAU, bus.exit_wid_IU_RAU,
                 one_hot, exp_w);
      end
    end
    $display("issue during exit: grt=%h wid=%0d", bus.grt_IU_IB, bus.wid_IU_OC);
    next_cycle();
    bus.req_IB_IU       = '0;
    bus.exit_ack_RAU_IU = 1'b1;
    next_cycle();
    bus.exit_ack_RAU_IU = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.exit_req_IB_IU = 8'h01;
    next_cycle();
    bus.exit_req_IB_IU = 8'h00;
    @(negedge clk);
    checks++;
    if (bus.exit_valid_IU_RAU !== 1'b1 || bus.exit_wid_IU_RAU !== 3'd0) begin
      errors++;
      $display("FAIL midreset_pre: exit_valid=%b exit_wid=%0d required 1/0",
               bus.exit_valid_IU_RAU, bus.exit_wid_IU_RAU);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.exit_valid_IU_RAU !== 1'b0 || bus.active_IU !== 8'h00) begin
      errors++;
      $display("FAIL midreset_async: exit_valid=%b active=%h required 0/00",
               bus.exit_valid_IU_RAU, bus.active_IU);
    end
    $display("mid reset: exit_valid=%b active=%h", bus.exit_valid_IU_RAU, bus.active_IU);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_IB_IU      = 8'hFF;
    bus.exit_req_IB_IU = 8'hFF;
    @(negedge clk);
    checks++;
    if (bus.grt_IU_IB !== 8'h00 || bus.exit_grt_IU_IB !== 8'h00 || bus.valid_IU_OC !== 1'b0) begin
      errors++;
      $display("FAIL midreset_nogrant: grt=%h exit_grt=%h valid=%b required 00/00/0",
               bus.grt_IU_IB, bus.exit_grt_IU_IB, bus.valid_IU_OC);
    end
    next_cycle();
    bus.exit_req_IB_IU   = 8'h00;
    bus.launch_valid_RAU = 1'b1;
    bus.launch_wid_RAU   = 3'd3;
    @(negedge clk);
    checks++;
    if (bus.grt_IU_IB !== 8'h00) begin
      errors++;
      $display("FAIL midreset_launch_cycle: grt=%h required 00", bus.grt_IU_IB);
    end
    next_cycle();
    bus.launch_valid_RAU = 1'b0;
    exp_q.push_back(3'd3);
    @(negedge clk);
    checks++;
    if (bus.valid_IU_OC !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL relaunch_valid: valid=%b required 1", bus.valid_IU_OC);
    end else begin
      exp_w = exp_q.pop_front();
      one_hot = NW'(1) << exp_w;
      checks++;
      if (bus.grt_IU_IB !== one_hot || bus.wid_IU_OC !== exp_w) begin
        errors++;
        $display("FAIL relaunch_grant: grt=%h wid=%0d required %h/%0d",
                 bus.grt_IU_IB, bus.wid_IU_OC, one_hot, exp_w);
      end
    end
    $display("relaunch: grt=%h wid=%0d", bus.grt_IU_IB, bus.wid_IU_OC);
    next_cycle();
    bus.req_IB_IU = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_stall();
    test_exit();
    test_exit_issue_conflict();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || exit_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d issue / %0d exit entries left, required 0",
               exp_q.size(), exit_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
